// File: rtl/push_pkg.sv
// Shared types for the pushbutton move generator: FSM states, direction
// encoding and small helpers over the one-hot button vector.
package push_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        HOLD,
        REPEAT,
        WAIT_REL
    } kstate_t;

    // Bit index of each button in the packed button/move vectors
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    function automatic logic [NUM_BTN-1:0] dir_mask(input dir_t d);
        logic [NUM_BTN-1:0] m;
        m    = '0;
        m[d] = 1'b1;
        return m;
    endfunction

    function automatic dir_t dir_of(input logic [NUM_BTN-1:0] m);
        dir_t d;
        d = UP;
        for (int i = 0; i < NUM_BTN; i++)
            if (m[i]) d = dir_t'(i[1:0]);
        return d;
    endfunction

    // True when exactly one bit is set
    function automatic logic is_lone(input logic [NUM_BTN-1:0] m);
        return (m != '0) && ((m & (m - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer followed by a stable-time debouncer.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btn};
    end

    // Count cycles of disagreement; flip the level once it has lasted DEB_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_move_gen.sv
// Turns four bouncing pushbuttons into single-cycle move pulses with
// optional auto-repeat while one button is held.
module key_move_gen #(
    parameter int DEB_CYCLES   = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 20000000,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic en,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic key_busy
);

    import push_pkg::*;

    localparam int            HW        = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int            RW        = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RATE_LAST = RW'((REPEAT_RATE > 1) ? REPEAT_RATE - 1 : 0);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] lat_mask;
    logic [NUM_BTN-1:0] move_q;
    logic               others;
    logic               held;
    kstate_t            state;
    dir_t               dir_q;
    logic [HW-1:0]      hold_cnt;
    logic [RW-1:0]      rate_cnt;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (raw[g]),
            .level (deb[g])
        );
    end

    assign lat_mask = dir_mask(dir_q);
    assign others   = |(deb & ~lat_mask);
    assign held     = |(deb & lat_mask);

    // The flop holds the pulse; en gates it combinationally so a game that
    // drops en mid-cycle never sees a move in that same cycle.
    assign {move_right, move_left, move_down, move_up} = move_q & {NUM_BTN{en}};

    // Move FSM with hold/repeat timers; move_q and key_busy are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_q    <= UP;
            hold_cnt <= '0;
            rate_cnt <= '0;
            move_q   <= '0;
            key_busy <= 1'b0;
        end else begin
            move_q <= '0;
            case (state)
                IDLE: begin
                    if (en && is_lone(deb)) begin
                        state    <= FIRE;
                        dir_q    <= dir_of(deb);
                        move_q   <= deb;
                        key_busy <= 1'b1;
                    end else if (!en && (deb != '0)) begin
                        // A press seen while disabled must be released first,
                        // otherwise raising en would fire from a stale hold.
                        state    <= WAIT_REL;
                        key_busy <= 1'b1;
                    end else begin
                        key_busy <= 1'b0;
                    end
                end
                FIRE: begin
                    hold_cnt <= '0;
                    state    <= (REPEAT_EN != 0) ? HOLD : WAIT_REL;
                end
                HOLD, REPEAT: begin
                    if (!en || others) begin
                        state <= WAIT_REL;
                    end else if (!held) begin
                        state    <= IDLE;
                        key_busy <= 1'b0;
                    end else if (state == HOLD) begin
                        if (hold_cnt >= HOLD_LAST) begin
                            state    <= REPEAT;
                            rate_cnt <= '0;
                            move_q   <= lat_mask;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end else begin
                        if (rate_cnt >= RATE_LAST) begin
                            rate_cnt <= '0;
                            move_q   <= lat_mask;
                        end else begin
                            rate_cnt <= rate_cnt + RW'(1);
                        end
                    end
                end
                WAIT_REL: begin
                    if (deb == '0) begin
                        state    <= IDLE;
                        key_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
